usb_input_event_encoder: RTL

- Debounces CHANNELS user inputs and converts each debounced edge into one ASCII byte for the CDC bulk IN stream.
- Rising edge on channel k emits UP_BASE+k; falling edge emits LO_BASE+k. Defaults give 'A'/'a' for channel 0, 'B'/'b' for channel 1, and so on.
- Debounce time is counted in USB frames, using changes of the SOF frame number, not clock cycles.
- Sits between the tile ui_in pins and the CDC IN FIFO write port. It generalises the earlier single-input, single-character debouncer.

---
 rtl/usb_dev_pkg.sv | 20 ++
 rtl/sync_fifo.sv | 61 ++++++
 rtl/usb_input_event_encoder.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/usb_dev_pkg.sv
// Shared definitions for the USB CDC device blocks: frame number width,
// default event character bases and the edge-to-character mapping.
package usb_dev_pkg;

    localparam int FRAME_W = 11;

    localparam logic [7:0] UP_BASE_DEF = 8'h41;
    localparam logic [7:0] LO_BASE_DEF = 8'h61;

    // 8-bit wrap-around arithmetic; channel numbers never need a carry.
    function automatic logic [7:0] char_of(
        input logic [7:0] ch,
        input logic       pol,
        input logic [7:0] up_base = UP_BASE_DEF,
        input logic [7:0] lo_base = LO_BASE_DEF
    );
        return pol ? (up_base + ch) : (lo_base + ch);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small first-word-fall-through FIFO with synchronous flush; push while full
// is accepted only together with a pop, leaving the occupancy unchanged.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             push_ok;
    logic             pop_ok;

    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == (AW+1)'(DEPTH));
    assign pop_ok     = pop_i && !empty_o;
    assign push_ok    = push_i && (!full_o || pop_ok);
    assign pop_data_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (push_ok && !pop_ok) begin
                count_q <= count_q + (AW+1)'(1);
            end else if (pop_ok && !push_ok) begin
                count_q <= count_q - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/usb_input_event_encoder.sv
// Debounces user inputs against USB frame ticks and queues one ASCII byte per
// committed edge for the CDC bulk IN stream.
module usb_input_event_encoder
    import usb_dev_pkg::*;
#(
    parameter int         CHANNELS        = 8,
    parameter int         DEBOUNCE_FRAMES = 10,
    parameter int         FIFO_DEPTH      = 4,
    parameter logic [7:0] UP_BASE         = UP_BASE_DEF,
    parameter logic [7:0] LO_BASE         = LO_BASE_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] in_i,
    input  logic [FRAME_W-1:0]  frame_i,
    input  logic                enable_i,
    output logic [7:0]          out_data_o,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [CHANNELS-1:0] state_o,
    output logic [7:0]          drop_cnt_o
);

    localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
    localparam int SW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_FRAMES - 1);

    logic [CHANNELS-1:0] sync1_q, sync2_q;
    logic [FRAME_W-1:0]  frame_prev_q;
    logic [CW-1:0]       cnt_q [CHANNELS];
    logic [CW-1:0]       cnt_d [CHANNELS];
    logic [CHANNELS-1:0] state_q, state_d;
    logic [CHANNELS-1:0] pending_q, pending_d;
    logic [CHANNELS-1:0] pol_q, pol_d;
    logic [7:0]          drop_q, drop_d;

    logic                tick;
    logic [SW-1:0]       sel;
    logic                push;
    logic [7:0]          push_char;
    logic                fifo_full;
    logic                fifo_empty;

    assign tick = enable_i && (frame_i != frame_prev_q);

    // Lowest-index pending channel wins the single push slot per clock.
    always_comb begin
        sel = '0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (pending_q[k]) begin
                sel = SW'(k);
            end
        end
    end

    assign push      = enable_i && (|pending_q) && !fifo_full;
    assign push_char = char_of(8'(sel), pol_q[sel], UP_BASE, LO_BASE);

    always_comb begin
        int drops;
        int total;
        state_d   = state_q;
        pending_d = pending_q;
        pol_d     = pol_q;
        drops     = 0;
        for (int k = 0; k < CHANNELS; k++) begin
            cnt_d[k] = cnt_q[k];
        end
        if (push) begin
            pending_d[sel] = 1'b0;
        end
        if (!enable_i) begin
            pending_d = '0;
            for (int k = 0; k < CHANNELS; k++) begin
                cnt_d[k] = '0;
            end
        end else if (tick) begin
            for (int k = 0; k < CHANNELS; k++) begin
                if (sync2_q[k] == state_q[k]) begin
                    cnt_d[k] = '0;
                end else if (cnt_q[k] == CNT_LAST) begin
                    cnt_d[k]     = '0;
                    state_d[k]   = sync2_q[k];
                    pol_d[k]     = sync2_q[k];
                    pending_d[k] = 1'b1;
                    // A commit landing on the entry being pushed replaces it cleanly.
                    if (pending_q[k] && !(push && (int'(sel) == k))) begin
                        drops++;
                    end
                end else begin
                    cnt_d[k] = cnt_q[k] + CW'(1);
                end
            end
        end
        total  = int'(drop_q) + drops;
        drop_d = (total > 255) ? 8'hFF : 8'(total);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            frame_prev_q <= '0;
            state_q      <= '0;
            pending_q    <= '0;
            pol_q        <= '0;
            drop_q       <= '0;
            for (int k = 0; k < CHANNELS; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            sync1_q      <= in_i;
            sync2_q      <= sync1_q;
            frame_prev_q <= frame_i;
            state_q      <= state_d;
            pending_q    <= pending_d;
            pol_q        <= pol_d;
            drop_q       <= drop_d;
            for (int k = 0; k < CHANNELS; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (!enable_i),
        .push_i      (push),
        .push_data_i (push_char),
        .pop_i       (out_ready_i),
        .pop_data_o  (out_data_o),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign out_valid_o = !fifo_empty;
    assign state_o     = state_q;
    assign drop_cnt_o  = drop_q;

endmodule
